uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Transmit half of the full UART. Accepts one byte from the host bus, builds a fixed
//  11-bit-time serial frame (start, 7/8 data LSB-first, optional parity, stop padding),
//  and shifts it out on tx at the programmed bit time. Frame config matches the receiver:
//  eight, pen, ohel.
// PARAMETERS
//  CNT_W   19   width of bit-time counter and of port k
// PORTS
//  clk      in   1       system clock, all logic on rising edge
//  reset    in   1       synchronous, active-high
//  k        in   CNT_W   clocks per bit time; 0 is treated as 1
//  eight    in   1       1 = 8 data bits, 0 = 7 data bits (data[6:0])
//  pen      in   1       1 = parity bit enabled
//  ohel     in   1       parity sense: 1 = odd, 0 = even
//  load     in   1       single-cycle write strobe, data valid same cycle
//  data     in   8       byte to send
//  tx       out  1       serial line, idle high
//  tx_rdy   out  1       1 = idle, load accepted
//  tx_done  out  1       one-cycle pulse at end of frame
// BEHAVIOUR
//  Reset: tx=1, tx_rdy=1, tx_done=0, bit/clk counters=0, shift reg all 1s, state IDLE.
//   Reset mid-frame aborts; tx=1 the next cycle.
//  States: IDLE -> SHIFT -> IDLE. No other states.
//  IDLE: load=1 captures data, eight, pen, ohel and k into holding regs. Next cycle:
//   tx_rdy=0, tx=0 (start bit), state SHIFT. load=0 leaves everything unchanged.
//  Frame: 11 bit positions b0..b10, b0=0 (start).
//   eight=1,pen=1: b1..b8=d0..d7, b9=P,  b10=1
//   eight=1,pen=0: b1..b8=d0..d7, b9=1,  b10=1
//   eight=0,pen=1: b1..b7=d0..d6, b8=P,  b9..b10=1
//   eight=0,pen=0: b1..b7=d0..d6, b8..b10=1
//   P = (XOR of the transmitted data bits) XOR ohel.
//  SHIFT: each bit held exactly k clocks (k=0 -> 1). Clock counter counts 0..k-1,
//   advances the bit index at k-1. Total frame is 11*k clocks starting with the
//   first tx=0 cycle.
//  End: in the last clock of b10, tx_done=1 for that single cycle. Next cycle tx_rdy=1,
//   tx=1, state IDLE.
//  load while tx_rdy=0 is ignored; the frame in flight is not disturbed.
//  load in the first cycle tx_rdy=1 after a frame is accepted (back-to-back frames,
//   no extra idle time beyond that one cycle).
//  Config and k inputs changing mid-frame have no effect until the next load.
//  tx is driven from a register, glitch-free.
// TESTING
//  1 k=4, eight=1,pen=1,ohel=0, data=0x55 -> tx = 0,1,0,1,0,1,0,1,0,0,1, each held
//    4 clks. tx_done pulses at clk 44 after start. tx_rdy high the next clk.
//  2 k=4, eight=0,pen=1,ohel=1, data=0xC1 -> tx = 0,1,0,0,0,0,0,1,1,1,1 (P=1, d7 ignored).
//  3 k=1, eight=0,pen=0, data=0xFF -> tx = 0 then ten 1s, 11 clks total. k=0 gives the
//    identical waveform.
//  4 k=4, load 0xA5 then load 0x00 at clk 10 of the frame -> 0xA5 frame unchanged,
//    0x00 never sent, tx_done pulses once.
//  5 k=8, assert reset at clk 30 of a frame -> next clk tx=1, tx_rdy=1, tx_done=0.
//    Subsequent load 0x3C transmits a correct frame.
//  6 k=2, load 0x81 then load 0x7E in the first tx_rdy=1 cycle -> two complete frames,
//    one idle-high clk between them, two tx_done pulses.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter producing a fixed 11-bit-time frame.
// Supports 7/8 data bits with optional odd/even parity, LSB first.
module uart_tx_engine #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] k,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  input  logic             load,
  input  logic [7:0]       data,
  output logic             tx,
  output logic             tx_rdy,
  output logic             tx_done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state;
  logic [10:0]      r_shift;
  logic [CNT_W-1:0] r_k;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic             r_rdy;
  logic             r_done;
  logic             w_par;
  logic [10:0]      w_frame;
  logic [CNT_W-1:0] w_k_eff;
  logic             w_wrap;
  logic             w_end;
  logic [CNT_W-1:0] w_cnt_n;
  logic [3:0]       w_bit_n;
  // In 7-bit mode d7 is excluded from both the frame and the parity.
  assign w_par   = ^(eight ? data : {1'b0, data[6:0]}) ^ ohel;
  assign w_frame = eight ? {1'b1, pen ? w_par : 1'b1, data, 1'b0}
                         : {2'b11, pen ? w_par : 1'b1, data[6:0], 1'b0};
  assign w_k_eff = (k == '0) ? CNT_W'(1) : k;
  assign w_wrap  = r_cnt == r_k - CNT_W'(1);
  assign w_end   = w_wrap && r_bit == 4'd10;
  assign w_cnt_n = w_wrap ? '0 : r_cnt + CNT_W'(1);
  assign w_bit_n = r_bit + {3'b0, w_wrap};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '1;
      r_k     <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_rdy   <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_state == IDLE) begin
      r_done <= 1'b0;
      if (load) begin
        r_state <= SHIFT;
        r_shift <= w_frame;
        r_k     <= w_k_eff;
        r_cnt   <= '0;
        r_bit   <= '0;
        r_rdy   <= 1'b0;
      end
    end else if (w_end) begin
      r_state <= IDLE;
      r_shift <= '1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_rdy   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_n;
      r_bit  <= w_bit_n;
      r_done <= w_bit_n == 4'd10 && w_cnt_n == r_k - CNT_W'(1);
      if (w_wrap) r_shift <= {1'b1, r_shift[10:1]};
    end
  end
  assign tx      = r_shift[0];
  assign tx_rdy  = r_rdy;
  assign tx_done = r_done;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: randomized scoreboard bench comparing the serial waveform
// against a frame model built from data bits, parity rule and bit time.
module tb_uart_tx_engine;
  localparam int CNT_W = 19;
  typedef struct {
    logic [10:0] bits;
    int          kk;
  } frame_t;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] k = '0;
  logic             eight = 1'b0;
  logic             pen = 1'b0;
  logic             ohel = 1'b0;
  logic             load = 1'b0;
  logic [7:0]       data = '0;
  logic             tx;
  logic             tx_rdy;
  logic             tx_done;
  logic             rst_q = 1'b1;
  frame_t           exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               pos = -1;
  int               frames_done = 0;
  uart_tx_engine #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .k(k), .eight(eight), .pen(pen), .ohel(ohel),
    .load(load), .data(data), .tx(tx), .tx_rdy(tx_rdy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= reset;
  function automatic frame_t model(logic [7:0] d, logic e, logic p, logic o, int kin);
    frame_t f;
    int nd;
    int idx;
    logic [7:0] used;
    nd = e ? 8 : 7;
    used = e ? d : (d & 8'h7f);
    f.bits = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) f.bits[1 + i] = d[i];
    idx = 1 + nd;
    if (p) f.bits[idx] = ($countones(used) % 2 == 1) ^ o;
    f.kk = (kin == 0) ? 1 : kin;
    return f;
  endfunction
  function automatic void chk(string name, logic act, logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
    end
  endfunction
  // Monitor: walks each expected frame clock by clock.
  frame_t cur;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("reset_tx", tx, 1'b1);
        chk("reset_rdy", tx_rdy, 1'b1);
        chk("reset_done", tx_done, 1'b0);
        pos = -1;
      end else begin
        if (pos == -2) begin
          chk("end_rdy", tx_rdy, 1'b1);
          chk("end_tx", tx, 1'b1);
          pos = -1;
          frames_done++;
        end else if (pos == -1 && tx_rdy == 1'b0) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame at %0t: got busy expected idle", $time);
            pos = -3;
          end else begin
            cur = exp_q.pop_front();
            pos = 0;
          end
        end else if (pos == -1) begin
          chk("idle_tx", tx, 1'b1);
          chk("idle_done", tx_done, 1'b0);
        end else if (pos == -3 && tx_rdy) pos = -1;
        if (pos >= 0) begin
          chk("frame_tx", tx, cur.bits[pos / cur.kk]);
          chk("frame_done", tx_done, pos == 11 * cur.kk - 1);
          chk("frame_rdy", tx_rdy, 1'b0);
          pos++;
          if (pos == 11 * cur.kk) pos = -2;
        end
      end
    end
  end
  // Waits for tx_rdy while scribbling on inputs to prove busy loads are ignored.
  task automatic wait_rdy(input bit noise);
    int n;
    n = 0;
    while (!tx_rdy && n < 4000) begin
      if (noise) begin
        load = $urandom_range(0, 3) == 0;
        data = 8'($urandom);
        {eight, pen, ohel} = 3'($urandom);
        k = CNT_W'($urandom_range(0, 9));
      end
      @(negedge clk);
      n++;
    end
    load = 1'b0;
    if (!tx_rdy) begin
      errors++;
      $display("FAIL rdy_timeout at %0t: got tx_rdy=0 expected 1", $time);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic e, input logic p, input logic o,
                      input int kin, input int gap, input bit noise);
    wait_rdy(noise);
    repeat (gap) @(negedge clk);
    data = d; eight = e; pen = p; ohel = o; k = CNT_W'(kin); load = 1'b1;
    exp_q.push_back(model(d, e, p, o, kin));
    @(negedge clk);
    load = 1'b0;
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(8'h55, 1, 1, 0, 4, 0, 0);
    send(8'hC1, 0, 1, 1, 4, 0, 0);
    send(8'hFF, 0, 0, 0, 1, 0, 0);
    send(8'hFF, 0, 0, 0, 0, 0, 0);
    send(8'hA5, 1, 0, 0, 4, 0, 0);
    repeat (8) @(negedge clk);
    data = 8'h00; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    send(8'h81, 1, 1, 1, 2, 0, 0);
    send(8'h7E, 1, 1, 0, 2, 0, 0);
    send(8'h33, 1, 0, 1, 8, 0, 0);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(8'h3C, 1, 1, 0, 8, 0, 0);
    for (int i = 0; i < 40; i++)
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 6), $urandom_range(0, 2), 1);
    wait_rdy(0);
    n = 0;
    while ((exp_q.size() != 0 || pos != -1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || frames_done != 48) begin
      errors++;
      $display("FAIL drain: got %0d frames done, %0d pending expected 48 done, 0 pending",
               frames_done, exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
